// File: rtl/pmod_dac_spi_receiver.sv
// SPI mode-0 responder for the PMOD DAC link: recovers 16-bit frames into an input
// register and moves them to a DAC register under LDAC_N, like the real device.
module pmod_dac_spi_receiver #(
    parameter int RESOLUTION  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_din,
    input  logic                  spi_ldac_n,
    output logic [RESOLUTION-1:0] input_reg,
    output logic [RESOLUTION-1:0] dac_value,
    output logic                  frame_valid,
    output logic                  dac_update,
    output logic                  frame_err,
    output logic [7:0]            err_count,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    localparam int CNT_W = $clog2(RESOLUTION) + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECEIVE = 2'd1;
    localparam logic [1:0] ST_OVERRUN = 2'd2;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic [SYNC_STAGES-1:0] ldac_sync_q, ldac_sync_d;
    logic cs_hist_q, sclk_hist_q, ldac_hist_q;

    logic [1:0]            state_q, state_d;
    logic [RESOLUTION-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RESOLUTION-1:0] input_q, input_d;
    logic [RESOLUTION-1:0] dac_q, dac_d;
    logic [7:0]            err_q, err_d;
    logic                  fv_q, fv_d;
    logic                  du_q, du_d;
    logic                  fe_q, fe_d;

    logic cs_s, sclk_s, din_s, ldac_s;
    logic cs_fall, cs_rise, sclk_rise, ldac_fall, cnt_full;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign din_s  = din_sync_q[SYNC_STAGES-1];
    assign ldac_s = ldac_sync_q[SYNC_STAGES-1];

    // Edges are taken between the last sync stage and its history flop only.
    assign cs_fall   = cs_hist_q & ~cs_s;
    assign cs_rise   = ~cs_hist_q & cs_s;
    assign sclk_rise = ~sclk_hist_q & sclk_s;
    assign ldac_fall = ldac_hist_q & ~ldac_s;
    assign cnt_full  = (cnt_q == CNT_W'(RESOLUTION));

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], spi_din};
        ldac_sync_d = {ldac_sync_q[SYNC_STAGES-2:0], spi_ldac_n};
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        input_d = input_q;
        dac_d   = dac_q;
        err_d   = err_q;
        fv_d    = 1'b0;
        du_d    = 1'b0;
        fe_d    = 1'b0;

        // LDAC load first so a coincident transparent load below wins.
        if (ldac_fall) begin
            dac_d = input_q;
            du_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_full) begin
                        input_d = shift_q;
                        fv_d    = 1'b1;
                        if (!ldac_s) begin
                            dac_d = shift_q;
                            du_d  = 1'b1;
                        end
                    end else begin
                        fe_d = 1'b1;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                end else if (sclk_rise) begin
                    if (cnt_full) begin
                        state_d = ST_OVERRUN;
                    end else begin
                        shift_d = {shift_q[RESOLUTION-2:0], din_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OVERRUN: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    fe_d    = 1'b1;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            din_sync_q  <= '0;
            ldac_sync_q <= '1;
            cs_hist_q   <= 1'b1;
            sclk_hist_q <= 1'b1;
            ldac_hist_q <= 1'b1;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            input_q     <= '0;
            dac_q       <= '0;
            err_q       <= '0;
            fv_q        <= 1'b0;
            du_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            din_sync_q  <= din_sync_d;
            ldac_sync_q <= ldac_sync_d;
            cs_hist_q   <= cs_s;
            sclk_hist_q <= sclk_s;
            ldac_hist_q <= ldac_s;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            input_q     <= input_d;
            dac_q       <= dac_d;
            err_q       <= err_d;
            fv_q        <= fv_d;
            du_q        <= du_d;
            fe_q        <= fe_d;
        end
    end

    assign input_reg   = input_q;
    assign dac_value   = dac_q;
    assign frame_valid = fv_q;
    assign dac_update  = du_q;
    assign frame_err   = fe_q;
    assign err_count   = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_pmod_dac_spi_receiver.sv
// Self-checking bench for pmod_dac_spi_receiver: frames are driven on the pins and
// recovered values are checked against a scoreboard of expected frames/DAC loads.
module tb_pmod_dac_spi_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_din = 1'b0;
    logic        spi_ldac_n = 1'b1;
    logic [15:0] input_reg, dac_value;
    logic        frame_valid, dac_update, frame_err, busy;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0, du_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int fv0, du0, fe0, both0;

    logic [15:0] exp_frame_q[$];
    logic [15:0] exp_dac_q[$];

    pmod_dac_spi_receiver #(.RESOLUTION(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_din(spi_din), .spi_ldac_n(spi_ldac_n),
        .input_reg(input_reg), .dac_value(dac_value),
        .frame_valid(frame_valid), .dac_update(dac_update), .frame_err(frame_err),
        .err_count(err_count), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard monitor: sample on the falling edge, pop on each output pulse.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            if (exp_frame_q.size() == 0) check("unexpected_frame_valid", 1, 0);
            else check("input_reg", {16'h0, input_reg}, {16'h0, exp_frame_q.pop_front()});
        end
        if (dac_update) begin
            du_cnt++;
            if (exp_dac_q.size() == 0) check("unexpected_dac_update", 1, 0);
            else check("dac_value", {16'h0, dac_value}, {16'h0, exp_dac_q.pop_front()});
        end
        if (frame_err) fe_cnt++;
        if (frame_valid && dac_update) both_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic snap();
        fv0 = fv_cnt; du0 = du_cnt; fe0 = fe_cnt; both0 = both_cnt;
    endtask

    task automatic send_bits(input logic [15:0] val, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_din = (i < 16) ? val[15-i] : 1'b0;
            wait_clks(4);
            spi_sclk = 1'b1;
            wait_clks(4);
            spi_sclk = 1'b0;
        end
    endtask

    // Full transaction; the CS_N rise is left to the caller via end_frame.
    task automatic start_frame(input logic [15:0] val, input int nbits);
        spi_cs_n = 1'b0;
        wait_clks(4);
        send_bits(val, nbits);
        wait_clks(4);
    endtask

    task automatic end_frame();
        spi_cs_n = 1'b1;
        wait_clks(8);
        @(negedge clk);
        check("busy_after_frame", {31'h0, busy}, 0);
    endtask

    initial begin
        // Reset
        wait_clks(4);
        rst = 1'b1;
        @(negedge clk);
        check("rst_input_reg", {16'h0, input_reg}, 0);
        check("rst_dac_value", {16'h0, dac_value}, 0);
        check("rst_err_count", {24'h0, err_count}, 0);
        check("rst_pulses", {29'h0, frame_valid, dac_update, frame_err}, 0);
        check("rst_busy", {31'h0, busy}, 0);

        // Good frame with LDAC_N high, then an LDAC_N pulse
        snap();
        exp_frame_q.push_back(16'hA5C3);
        start_frame(16'hA5C3, 16);
        @(negedge clk);
        check("busy_in_frame", {31'h0, busy}, 1);
        end_frame();
        check("a5c3_fv_count", fv_cnt - fv0, 1);
        check("a5c3_du_count", du_cnt - du0, 0);
        check("a5c3_dac_held", {16'h0, dac_value}, 0);
        snap();
        exp_dac_q.push_back(16'hA5C3);
        spi_ldac_n = 1'b0;
        wait_clks(6);
        spi_ldac_n = 1'b1;
        wait_clks(6);
        check("ldac_du_count", du_cnt - du0, 1);
        check("ldac_dac_value", {16'h0, dac_value}, 32'hA5C3);

        // Transparent load: the LDAC_N fall itself reloads A5C3 first
        exp_dac_q.push_back(16'hA5C3);
        spi_ldac_n = 1'b0;
        wait_clks(6);
        snap();
        exp_frame_q.push_back(16'h1000);
        exp_dac_q.push_back(16'h1000);
        start_frame(16'h1000, 16);
        end_frame();
        spi_ldac_n = 1'b1;
        wait_clks(6);
        check("transp_same_cycle", both_cnt - both0, 1);
        check("transp_dac_value", {16'h0, dac_value}, 32'h1000);

        // Short and long frames
        snap();
        start_frame(16'hFFFF, 15);
        end_frame();
        check("short_fe_count", fe_cnt - fe0, 1);
        check("short_err_count", {24'h0, err_count}, 1);
        check("short_input_reg", {16'h0, input_reg}, 32'h1000);
        start_frame(16'hFFFF, 17);
        end_frame();
        check("long_fe_count", fe_cnt - fe0, 2);
        check("long_err_count", {24'h0, err_count}, 2);
        check("long_input_reg", {16'h0, input_reg}, 32'h1000);

        // Saturation with zero-edge frames
        snap();
        for (int i = 0; i < 260; i++) begin
            spi_cs_n = 1'b0;
            wait_clks(4);
            spi_cs_n = 1'b1;
            wait_clks(4);
        end
        wait_clks(6);
        check("sat_err_count", {24'h0, err_count}, 255);
        check("sat_fe_count", fe_cnt - fe0, 260);
        check("sat_fv_count", fv_cnt - fv0, 0);
        wait_clks(20);
        check("sat_hold", {24'h0, err_count}, 255);

        // Reset mid-frame
        snap();
        spi_cs_n = 1'b0;
        wait_clks(4);
        send_bits(16'hFF00, 8);
        rst = 1'b0;
        spi_cs_n = 1'b1;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(6);
        @(negedge clk);
        check("midrst_input_reg", {16'h0, input_reg}, 0);
        check("midrst_dac_value", {16'h0, dac_value}, 0);
        check("midrst_err_count", {24'h0, err_count}, 0);
        check("midrst_busy", {31'h0, busy}, 0);
        check("midrst_no_fe", fe_cnt - fe0, 0);
        exp_frame_q.push_back(16'h0F0F);
        start_frame(16'h0F0F, 16);
        end_frame();
        check("post_rst_frame", {16'h0, input_reg}, 32'h0F0F);

        // Simultaneous LDAC_N fall and good-frame CS_N rise
        exp_frame_q.push_back(16'h2000);
        start_frame(16'h2000, 16);
        end_frame();
        snap();
        exp_frame_q.push_back(16'h3000);
        exp_dac_q.push_back(16'h3000);
        start_frame(16'h3000, 16);
        spi_ldac_n = 1'b0;
        end_frame();
        spi_ldac_n = 1'b1;
        wait_clks(6);
        check("simul_du_count", du_cnt - du0, 1);
        check("simul_dac_value", {16'h0, dac_value}, 32'h3000);
        check("simul_input_reg", {16'h0, input_reg}, 32'h3000);

        check("frame_q_drained", exp_frame_q.size(), 0);
        check("dac_q_drained", exp_dac_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
